lcd_de_receiver: RTL
====================

Name: lcd_de_receiver

Overview:
- Receive-side counterpart of our DE-mode RGB LCD timing generator. It consumes lcd_de/lcd_rgb on the pixel clock.
- HS/VS are tied high on our panel link, so it recovers line and frame boundaries from DE alone.
- Regenerates 1-based pixel coordinates, measures the active geometry and reports lock and format errors.
- Sits at the loopback/capture end of the display path, feeding a frame-checker or capture buffer.

Parameters:
- H_DISP, 11'd800, expected active pixels per line
- V_DISP, 11'd480, expected active lines per frame
- VBLANK_MIN, 16'd2048, consecutive DE-low cycles that mark vertical blanking; must exceed horizontal blank (256) and be below vertical blank (45*1056)
- LOCK_FRAMES, 3'd2, consecutive good frames required to assert locked

Ports:
- lcd_clk  in  1  pixel clock
- sys_rst_n  in  1  asynchronous active-low reset
- lcd_de  in  1  data enable from link
- lcd_rgb  in  24  RGB888 pixel from link
- pix_valid  out  1  registered pixel strobe
- pix_data  out  24  registered pixel; 0 when pix_valid=0
- pix_xpos  out  11  column, 1..H_DISP; 0 when pix_valid=0
- pix_ypos  out  11  line, 1..V_DISP; 0 when pix_valid=0
- frame_start  out  1  1-cycle pulse coincident with pixel (1,1)
- line_end  out  1  1-cycle pulse, one cycle after the last pix_valid of a line
- meas_width  out  11  width of last completed line
- meas_height  out  11  line count of last completed frame
- locked  out  1  geometry stable and matching parameters
- fmt_err  out  1  1-cycle pulse on any geometry mismatch

Behaviour:
- Single clock lcd_clk. Reset asynchronous, active-low on sys_rst_n. All outputs registered, all 0 in reset. State resets to SEARCH.
- Latency: lcd_de/lcd_rgb sampled at edge k appear on pix_* after edge k (1 cycle).
- blank_cnt (16b): +1 each DE-low cycle, saturates at VBLANK_MIN, clears on DE high. vb_hit = 1-cycle pulse when blank_cnt goes VBLANK_MIN-1 -> VBLANK_MIN.
- States:
  - SEARCH: pix_valid held 0; vb_hit -> VBLANK.
  - VBLANK: DE rise -> ACTIVE with frame_start=1, x=1, y=1.
  - ACTIVE: DE high -> x+1 (saturate 2047). DE fall -> line_end, meas_width<=x, check x==H_DISP. DE rise -> x=1, y+1 (saturate 2047). vb_hit -> meas_height<=y, check y==V_DISP and frame width ok, then VBLANK.
- pix_valid = DE registered only in ACTIVE or on the VBLANK->ACTIVE transition cycle; never in SEARCH.
- Line check failure: fmt_err pulse at line_end and frame marked bad. Frame check failure: fmt_err pulse at vb_hit.
  - Both in the same cycle give a single pulse.
- good_cnt (3b): +1 on a good frame (saturate LOCK_FRAMES); locked=1 when good_cnt==LOCK_FRAMES. Any bad frame clears good_cnt and locked on the same edge as fmt_err.
- A one-cycle DE-low gap counts as a line boundary.
- DE high at reset release: stay in SEARCH until a full vb_hit, so a partial frame is never reported.
- Reset mid-frame: immediate return to SEARCH. Counters, meas_*, locked and flags cleared.

Test Plan:
- Driver-pattern frames (H_TOTAL 1056: 46 blank + 800 DE + 210 blank; 480 of 525 lines DE), 3 frames.
  - First frame output starts only after the initial vb_hit.
  - frame_start with xpos=1, ypos=1; last pixel at (800,480).
  - meas_width=800, meas_height=480; locked rises at end of 2nd full frame; fmt_err never.
- Inject one 799-pixel line in frame 4 -> fmt_err at that line_end, meas_width=799, locked drops; relocks after 2 further good frames.
- Frame with 481 active lines -> fmt_err pulse at vb_hit, meas_height=481, locked=0.
- Assert sys_rst_n low at line 200 -> all outputs 0 asynchronously; after release, no pix_valid until next vb_hit; then normal from (1,1).
- DE-low gap of 1 cycle between 800-pixel lines -> line_end pulses, ypos increments, no vb_hit. Gap of 2047 cycles -> no frame end. Gap of 2048 -> frame end.
- Pixel data check: lcd_rgb = {x,y} pattern -> pix_data matches input delayed by 1 cycle; pix_data=0 whenever pix_valid=0.

Source files
------------

// File: rtl/lcd_de_receiver.sv
// DE-only RGB LCD receiver: recovers line/frame boundaries from lcd_de, regenerates
// 1-based pixel coordinates, measures active geometry and reports lock/format errors.
module lcd_de_receiver #(
    parameter logic [10:0] H_DISP      = 11'd800,
    parameter logic [10:0] V_DISP      = 11'd480,
    parameter logic [15:0] VBLANK_MIN  = 16'd2048,
    parameter logic [2:0]  LOCK_FRAMES = 3'd2
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        lcd_de,
    input  logic [23:0] lcd_rgb,
    output logic        pix_valid,
    output logic [23:0] pix_data,
    output logic [10:0] pix_xpos,
    output logic [10:0] pix_ypos,
    output logic        frame_start,
    output logic        line_end,
    output logic [10:0] meas_width,
    output logic [10:0] meas_height,
    output logic        locked,
    output logic        fmt_err
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] blank_cnt, blank_nxt;
    logic        de_d;
    logic        vb_hit;
    logic [10:0] x_cnt, x_nxt;
    logic [10:0] y_cnt, y_nxt;
    logic        frame_bad, frame_bad_nxt;
    logic [2:0]  good_cnt, good_nxt;

    logic        valid_nxt;
    logic [23:0] data_nxt;
    logic [10:0] xpos_nxt, ypos_nxt;
    logic        fs_nxt, le_nxt;
    logic [10:0] mw_nxt, mh_nxt;
    logic        lock_nxt, err_nxt;
    logic        line_bad, frame_chk, frame_ok;

    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // vb_hit fires on the sample that takes blank_cnt from VBLANK_MIN-1 to VBLANK_MIN
    assign vb_hit    = !lcd_de && (blank_cnt == VBLANK_MIN - 16'd1);
    assign blank_nxt = lcd_de ? '0 :
                       (blank_cnt != VBLANK_MIN) ? blank_cnt + 16'd1 : blank_cnt;

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= SEARCH;
            blank_cnt   <= '0;
            de_d        <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            frame_bad   <= 1'b0;
            good_cnt    <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_xpos    <= '0;
            pix_ypos    <= '0;
            frame_start <= 1'b0;
            line_end    <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            locked      <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            blank_cnt   <= blank_nxt;
            de_d        <= lcd_de;
            x_cnt       <= x_nxt;
            y_cnt       <= y_nxt;
            frame_bad   <= frame_bad_nxt;
            good_cnt    <= good_nxt;
            pix_valid   <= valid_nxt;
            pix_data    <= data_nxt;
            pix_xpos    <= xpos_nxt;
            pix_ypos    <= ypos_nxt;
            frame_start <= fs_nxt;
            line_end    <= le_nxt;
            meas_width  <= mw_nxt;
            meas_height <= mh_nxt;
            locked      <= lock_nxt;
            fmt_err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        x_nxt         = x_cnt;
        y_nxt         = y_cnt;
        frame_bad_nxt = frame_bad;
        good_nxt      = good_cnt;
        valid_nxt     = 1'b0;
        data_nxt      = '0;
        xpos_nxt      = '0;
        ypos_nxt      = '0;
        fs_nxt        = 1'b0;
        le_nxt        = 1'b0;
        mw_nxt        = meas_width;
        mh_nxt        = meas_height;
        err_nxt       = 1'b0;
        line_bad      = 1'b0;
        frame_chk     = 1'b0;
        frame_ok      = 1'b0;

        case (state)
            SEARCH: begin
                if (vb_hit) begin
                    state_nxt = VBLANK;
                end
            end
            VBLANK: begin
                if (lcd_de) begin
                    state_nxt     = ACTIVE;
                    x_nxt         = 11'd1;
                    y_nxt         = 11'd1;
                    frame_bad_nxt = 1'b0;
                    fs_nxt        = 1'b1;
                    valid_nxt     = 1'b1;
                    data_nxt      = lcd_rgb;
                    xpos_nxt      = 11'd1;
                    ypos_nxt      = 11'd1;
                end
            end
            ACTIVE: begin
                if (lcd_de) begin
                    if (de_d) begin
                        x_nxt = sat_inc(x_cnt);
                    end else begin
                        x_nxt = 11'd1;
                        y_nxt = sat_inc(y_cnt);
                    end
                    valid_nxt = 1'b1;
                    data_nxt  = lcd_rgb;
                    xpos_nxt  = x_nxt;
                    ypos_nxt  = y_nxt;
                end else if (de_d) begin
                    le_nxt = 1'b1;
                    mw_nxt = x_cnt;
                    if (x_cnt != H_DISP) begin
                        line_bad      = 1'b1;
                        frame_bad_nxt = 1'b1;
                    end
                end
                if (vb_hit) begin
                    mh_nxt    = y_cnt;
                    frame_chk = 1'b1;
                    frame_ok  = (y_cnt == V_DISP) && !frame_bad_nxt;
                    state_nxt = VBLANK;
                end
            end
            default: state_nxt = SEARCH;
        endcase

        // a line error and a frame error in the same cycle collapse into one pulse
        if (line_bad || (frame_chk && !frame_ok)) begin
            err_nxt  = 1'b1;
            good_nxt = '0;
        end else if (frame_chk && (good_cnt != LOCK_FRAMES)) begin
            good_nxt = good_cnt + 3'd1;
        end
        lock_nxt = (good_nxt == LOCK_FRAMES);
    end

endmodule
